// File: rtl/tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_scheduler_if
// Function : Source-FIFO heads/pops and phy-facing word bus for tx_scheduler.
// Revision : 1.0
// ============================================================================
interface tx_scheduler_if;
  logic        link_en;
  logic [31:0] fifo0_data;
  logic        fifo0_empty;
  logic        fifo0_pop;
  logic [31:0] fifo1_data;
  logic        fifo1_empty;
  logic        fifo1_pop;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  grant;
  logic [1:0]  state;

  modport master (
    input  link_en,
    input  fifo0_data, fifo0_empty,
    input  fifo1_data, fifo1_empty,
    output fifo0_pop, fifo1_pop,
    output data_out, valid_out, grant, state
  );

  modport slave (
    output link_en,
    output fifo0_data, fifo0_empty,
    output fifo1_data, fifo1_empty,
    input  fifo0_pop, fifo1_pop,
    input  data_out, valid_out, grant, state
  );
endinterface
`default_nettype wire

// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_scheduler
// Function : Training sequence, then burst-limited round-robin of two FWFT
//            FIFOs into a registered 32-bit phy word stream.
// Revision : 1.0
// ============================================================================
module tx_scheduler #(
  parameter int          NUM_TRAIN  = 4,
  parameter logic [31:0] TRAIN_WORD = 32'hBCBC_BCBC,
  parameter logic [31:0] IDLE_WORD  = 32'h7C7C_7C7C,
  parameter int          BURST_MAX  = 4
) (
  input  wire logic      clk_2f,
  input  wire logic      reset,
  tx_scheduler_if.master sif
);

  localparam logic [3:0] c_train_last = 4'(NUM_TRAIN - 1);
  localparam logic [3:0] c_burst_max  = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic        r_valid;
  logic [1:0]  r_grant;
  logic [3:0]  r_train_cnt;
  logic [3:0]  r_burst;
  logic        r_last;

  logic       w_slot;
  logic       w_owner_ne;
  logic       w_other_ne;
  logic       w_serve;
  logic       w_sel;
  logic [3:0] w_next_burst;

  // A zero burst count only exists straight after reset; treating it as
  // "no burst in progress" makes FIFO 0 win the first arbitration.
  always_comb begin
    w_slot       = (r_state == ST_IDLE || r_state == ST_ACTIVE) && sif.link_en;
    w_owner_ne   = r_last ? !sif.fifo1_empty : !sif.fifo0_empty;
    w_other_ne   = r_last ? !sif.fifo0_empty : !sif.fifo1_empty;
    w_serve      = 1'b0;
    w_sel        = r_last;
    w_next_burst = r_burst;
    if (w_slot) begin
      if (w_owner_ne && r_burst != 4'd0 && r_burst < c_burst_max) begin
        w_serve      = 1'b1;
        w_next_burst = r_burst + 4'd1;
      end else if (w_other_ne) begin
        w_serve      = 1'b1;
        w_sel        = ~r_last;
        w_next_burst = 4'd1;
      end else if (w_owner_ne) begin
        w_serve      = 1'b1;
        w_next_burst = 4'd1;
      end
    end
  end

  assign sif.fifo0_pop = w_serve & ~w_sel;
  assign sif.fifo1_pop = w_serve &  w_sel;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_data      <= 32'h0;
      r_valid     <= 1'b0;
      r_grant     <= 2'b00;
      r_train_cnt <= 4'd0;
      r_burst     <= 4'd0;
      r_last      <= 1'b1;
    end else if (r_state != ST_RESET && !sif.link_en) begin
      r_state     <= ST_RESET;
      r_data      <= 32'h0;
      r_valid     <= 1'b0;
      r_grant     <= 2'b00;
      r_train_cnt <= 4'd0;
      r_burst     <= 4'd0;
      r_last      <= 1'b1;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (sif.link_en) begin
            r_state <= ST_TRAIN;
          end
        end
        ST_TRAIN: begin
          r_data  <= TRAIN_WORD;
          r_valid <= 1'b1;
          r_grant <= 2'b00;
          if (r_train_cnt == c_train_last) begin
            r_state     <= ST_IDLE;
            r_train_cnt <= 4'd0;
          end else begin
            r_train_cnt <= r_train_cnt + 4'd1;
          end
        end
        ST_IDLE, ST_ACTIVE: begin
          if (w_serve) begin
            r_data  <= w_sel ? sif.fifo1_data : sif.fifo0_data;
            r_valid <= 1'b1;
            r_grant <= w_sel ? 2'b10 : 2'b01;
            r_state <= ST_ACTIVE;
            r_last  <= w_sel;
            r_burst <= w_next_burst;
          end else begin
            r_data  <= IDLE_WORD;
            r_valid <= 1'b0;
            r_grant <= 2'b00;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end

  assign sif.data_out  = r_data;
  assign sif.valid_out = r_valid;
  assign sif.grant     = r_grant;
  assign sif.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_scheduler
// Function : Scoreboard bench: FIFO models feed the scheduler, expected words
//            are queued by the stimulus and popped by an output monitor.
// Revision : 1.0
// ============================================================================
module tb_tx_scheduler;

  logic clk_2f = 1'b0;
  logic reset  = 1'b1;

  tx_scheduler_if sif ();

  tx_scheduler #(
    .NUM_TRAIN (4),
    .TRAIN_WORD(32'hBCBC_BCBC),
    .IDLE_WORD (32'h7C7C_7C7C),
    .BURST_MAX (4)
  ) dut (
    .clk_2f(clk_2f),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  grant;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          first_v = -1;
  int          last_v  = -1;
  logic        p0      = 1'b0;
  logic        p1      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic refresh();
    sif.fifo0_empty = (q0.size() == 0);
    sif.fifo0_data  = (q0.size() != 0) ? q0[0] : 32'h0;
    sif.fifo1_empty = (q1.size() == 0);
    sif.fifo1_data  = (q1.size() != 0) ? q1[0] : 32'h0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    exp_q.push_back(e);
  endtask

  task automatic push_train();
    repeat (4) push_exp(32'hBCBC_BCBC, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #2;
  endtask

  task automatic neg();
    @(negedge clk_2f);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still expected after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  always @(posedge clk_2f) cyc++;

  // FIFO model: consume the heads popped at the edge just passed.
  always @(posedge clk_2f) begin
    #1;
    if (p0 && q0.size() != 0) void'(q0.pop_front());
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    p0 = 1'b0;
    p1 = 1'b0;
    refresh();
  end

  always @(negedge clk_2f) begin
    #4;
    p0 = sif.fifo0_pop;
    p1 = sif.fifo1_pop;
    checks++;
    if ((p0 && p1) || (p0 && q0.size() == 0) || (p1 && q1.size() == 0) ||
        ((p0 || p1) && sif.state < 2'd2)) begin
      errors++;
      $display("FAIL pop_legal: pop0=%b pop1=%b empty0=%0d empty1=%0d state=%0d required legal single pop",
               p0, p1, q0.size() == 0, q1.size() == 0, sif.state);
    end
  end

  always @(negedge clk_2f) begin
    if (sif.valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: got data=%h grant=%b expected no valid word", sif.data_out, sif.grant);
      end else begin
        m_e = exp_q.pop_front();
        if (sif.data_out !== m_e.data || sif.grant !== m_e.grant) begin
          errors++;
          $display("FAIL out_word: got data=%h grant=%b expected data=%h grant=%b",
                   sif.data_out, sif.grant, m_e.data, m_e.grant);
        end
      end
      if (sif.grant != 2'b00) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.link_en = 1'b0;
    refresh();
    repeat (2) tick();
    neg();
    check("rst_state", sif.state, 32'd0);
    check("rst_valid", sif.valid_out, 32'd0);
    check("rst_data", sif.data_out, 32'h0);
    check("rst_grant", sif.grant, 32'd0);
    check("rst_pops", {sif.fifo0_pop, sif.fifo1_pop}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    neg();
    check("hold_reset_state", sif.state, 32'd0);

    // Training with both FIFOs empty
    tick();
    sif.link_en = 1'b1;
    push_train();
    neg();
    check("train_k_state", sif.state, 32'd0);
    tick();
    neg();
    check("train_k1_state", sif.state, 32'd1);
    check("train_k1_valid", sif.valid_out, 32'd0);
    tick();
    neg();
    check("train_k2_valid", sif.valid_out, 32'd1);
    wait_drain(10);
    neg();
    check("idle_state", sif.state, 32'd2);
    check("idle_valid", sif.valid_out, 32'd0);
    check("idle_data", sif.data_out, 32'h7C7C_7C7C);
    check("idle_grant", sif.grant, 32'd0);

    // FIFO0 only: six back-to-back words
    tick();
    first_v = -1;
    for (int i = 1; i <= 6; i++) begin
      q0.push_back(32'(i));
      push_exp(32'(i), 2'b01);
    end
    refresh();
    wait_drain(20);
    check("fifo0_only_no_bubble", 32'(last_v - first_v), 32'd5);

    // Drop link_en in IDLE to restore pointer, then both FIFOs full
    tick();
    sif.link_en = 1'b0;
    tick();
    neg();
    check("drop_idle_state", sif.state, 32'd0);
    for (int i = 0; i < 8; i++) begin
      q0.push_back(32'hA0 + 32'(i));
      q1.push_back(32'hB0 + 32'(i));
    end
    refresh();
    sif.link_en = 1'b1;
    push_train();
    for (int i = 0; i < 4; i++) push_exp(32'hA0 + 32'(i), 2'b01);
    for (int i = 0; i < 4; i++) push_exp(32'hB0 + 32'(i), 2'b10);
    for (int i = 4; i < 8; i++) push_exp(32'hA0 + 32'(i), 2'b01);
    for (int i = 4; i < 8; i++) push_exp(32'hB0 + 32'(i), 2'b10);
    first_v = -1;
    wait_drain(40);
    check("rr_no_bubble", 32'(last_v - first_v), 32'd15);

    // FIFO1 runs dry after two words while FIFO0 waits
    tick();
    first_v = -1;
    q1.push_back(32'hC0);
    q1.push_back(32'hC1);
    refresh();
    push_exp(32'hC0, 2'b10);
    push_exp(32'hC1, 2'b10);
    push_exp(32'hD0, 2'b01);
    push_exp(32'hD1, 2'b01);
    push_exp(32'hD2, 2'b01);
    tick();
    q0.push_back(32'hD0);
    q0.push_back(32'hD1);
    q0.push_back(32'hD2);
    refresh();
    wait_drain(20);
    check("switch_no_bubble", 32'(last_v - first_v), 32'd4);

    // link_en dropped while ACTIVE
    tick();
    for (int i = 0; i < 8; i++) q0.push_back(32'hE0 + 32'(i));
    refresh();
    push_exp(32'hE0, 2'b01);
    push_exp(32'hE1, 2'b01);
    push_exp(32'hE2, 2'b01);
    tick();
    tick();
    tick();
    sif.link_en = 1'b0;
    neg();
    check("drop_pops", {sif.fifo0_pop, sif.fifo1_pop}, 32'd0);
    check("drop_active_state", sif.state, 32'd3);
    tick();
    neg();
    check("drop_next_state", sif.state, 32'd0);
    check("drop_next_valid", sif.valid_out, 32'd0);
    check("drop_next_data", sif.data_out, 32'h0);
    check("drop_words_before", exp_q.size(), 32'd0);
    tick();
    sif.link_en = 1'b1;
    push_train();
    for (int i = 3; i < 8; i++) push_exp(32'hE0 + 32'(i), 2'b01);
    wait_drain(30);

    // Asynchronous reset between edges in the middle of a burst
    tick();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(32'hF0 + 32'(i));
      q1.push_back(32'h60 + 32'(i));
    end
    refresh();
    push_exp(32'hF0, 2'b01);
    tick();
    @(negedge clk_2f);
    #1;
    reset = 1'b1;
    #1;
    check("arst_state", sif.state, 32'd0);
    check("arst_valid", sif.valid_out, 32'd0);
    check("arst_data", sif.data_out, 32'h0);
    check("arst_grant", sif.grant, 32'd0);
    check("arst_pops", {sif.fifo0_pop, sif.fifo1_pop}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    push_train();
    for (int i = 1; i < 5; i++) push_exp(32'hF0 + 32'(i), 2'b01);
    for (int i = 0; i < 4; i++) push_exp(32'h60 + 32'(i), 2'b10);
    for (int i = 5; i < 8; i++) push_exp(32'hF0 + 32'(i), 2'b01);
    for (int i = 4; i < 8; i++) push_exp(32'h60 + 32'(i), 2'b10);
    wait_drain(60);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_scheduler.md
# tx_scheduler

Transmit-side scheduler sitting directly in front of the phy transmitter's 32-bit `data_in`/`valid_in` input. After link enable it emits a fixed training sequence, then arbitrates round-robin with a burst limit between two first-word-fall-through source FIFOs. It pops at most one word per cycle and drives it, registered, to the phy. It runs on the same clock as the byte-striping stage, one 32-bit word per cycle.

## Interface
- `NUM_TRAIN`, 4: training words emitted after link enable (1..15).
- `TRAIN_WORD`, 32'hBCBC_BCBC: training pattern.
- `IDLE_WORD`, 32'h7C7C_7C7C: data_out value whenever valid_out=0 outside reset state.
- `BURST_MAX`, 4: max consecutive words from one FIFO while the other is non-empty (1..15).
- `clk_2f` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `link_en` in 1: link enable; level-sensitive.
- `fifo0_data` in 32: head word of FIFO 0, valid while `fifo0_empty`=0.
- `fifo0_empty` in 1: FIFO 0 empty.
- `fifo0_pop` out 1: combinational pop; head consumed at this edge.
- `fifo1_data`, `fifo1_empty`, `fifo1_pop`: same for FIFO 1.
- `data_out` out 32: word to phy `data_in`, registered.
- `valid_out` out 1: to phy `valid_in`, registered.
- `grant` out 2: one-hot source of current `data_out` word (00 for training/idle), registered.
- `state` out 2: 0 RESET, 1 TRAIN, 2 IDLE, 3 ACTIVE.

## Operation
- Reset values: state=RESET, data_out=0, valid_out=0, grant=00, train counter=0, burst counter=0, last-owner pointer=1 (so first grant goes to FIFO 0); pops=0.
- RESET: outputs held at reset values. If link_en=1 → TRAIN.
- TRAIN: each cycle data_out=TRAIN_WORD, valid_out=1, grant=00; after NUM_TRAIN words → IDLE. No pops.
- IDLE/ACTIVE slot rule, evaluated each cycle with link_en=1. Owner = last-owner pointer, other = the other FIFO.
  - If owner non-empty and burst<BURST_MAX: serve owner, burst+1.
  - Else if other non-empty: serve other, owner:=other, burst:=1.
  - Else if owner non-empty (burst hit max, other empty): serve owner, burst:=1.
  - Else: no word.
- Serving FIFO N: fifoN_pop=1 this cycle; at the edge data_out<=fifoN_data, valid_out<=1, grant<=one-hot N, state<=ACTIVE.
- No word: valid_out<=0, data_out<=IDLE_WORD, grant<=00, state<=IDLE; burst and pointer unchanged.
- link_en=0 in TRAIN/IDLE/ACTIVE: no pop this cycle; next edge state=RESET, outputs return to reset values, pointer and counters reset. Re-enable repeats the full training.
- Never both pops in one cycle; never pop an empty FIFO; pops always 0 in RESET/TRAIN.
- Counters saturate logic-wise: burst never exceeds BURST_MAX.

## Timing
- Pop-to-output latency 1 cycle: word popped in cycle k appears on data_out/valid_out in k+1.
- link_en rise at cycle k → first TRAIN_WORD valid at k+2 (RESET→TRAIN at edge k+1, output at edge k+2). Last training word at k+1+NUM_TRAIN; earliest pop in cycle k+1+NUM_TRAIN, data at k+2+NUM_TRAIN.
- Sustained throughput: one word per cycle while any FIFO non-empty; no bubble on owner switch.
- Asynchronous reset clears all registers immediately; pops drop combinationally with state=RESET.
- fifoN_empty/fifoN_data sampled in the same cycle pop is decided; FIFOs must update head by the next cycle.

## Test plan
- Reset then link_en=1, both FIFOs empty, NUM_TRAIN=4 → exactly 4 cycles of BCBC_BCBC valid, then valid_out=0, data_out=7C7C_7C7C, state=2, no pops.
- FIFO0 holds 0x00000001..0x00000006, FIFO1 empty → six consecutive valid words 1..6, grant=01, burst limit not enforced since other empty, no bubble.
- Both FIFOs full (A0.. / B0..), BURST_MAX=4 → output A0-A3, B0-B3, A4-A7..., grant toggles every 4 words, never both pops high.
- FIFO1 empties mid-burst after 2 words while FIFO0 non-empty → switch to FIFO0 next cycle with no gap; burst restarts at 1.
- link_en dropped during ACTIVE → pops 0 that cycle, next edge valid_out=0, data_out=0, state=0; re-enable → full 4-word training before any pop.
- Async reset asserted mid-burst between edges → outputs zero immediately, pops 0; after release with link_en=1 the first grant goes to FIFO0.
